// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared states, plate drive patterns and ADC channel codes for the touch scanner
package touch_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PEN_SETTLE,
    ST_PEN_SAMPLE,
    ST_X_SETTLE,
    ST_X_SAMPLE,
    ST_Y_SETTLE,
    ST_Y_SAMPLE,
    ST_ABORT,
    ST_GAP
  } state_e;

  // Plate bit order everywhere is {YM, YP, XM, XP}
  typedef struct packed {
    logic [3:0] drive;
    logic [3:0] oe;
  } drive_pat_t;

  localparam drive_pat_t PAT_OFF = '{drive: 4'b0000, oe: 4'b0000};
  // XP pulled high, YM pulled low: current flows only when the plates touch
  localparam drive_pat_t PAT_PEN = '{drive: 4'b0001, oe: 4'b1001};
  localparam drive_pat_t PAT_X   = '{drive: 4'b0001, oe: 4'b0011};
  localparam drive_pat_t PAT_Y   = '{drive: 4'b0100, oe: 4'b1100};

  localparam logic CH_XP = 1'b0;
  localparam logic CH_YP = 1'b1;

endpackage

// File: rtl/touch_avg_acc.sv
// rtl/touch_avg_acc.sv - per-axis sample accumulator with truncating power-of-two average
module touch_avg_acc #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [ADC_W-1:0] sample_i,
  output logic [ADC_W-1:0] avg_next_o
);

  localparam int ACC_W = ADC_W + AVG_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d, sum;

  // Next accumulator value; the average is taken from the sum that includes the
  // current sample so the caller can capture it on the final ACK cycle.
  always_comb begin
    sum = acc_q + ACC_W'(sample_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = sum;
    end
    avg_next_o = sum[ACC_W-1:AVG_LOG2];
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/touch_scan_ctrl.sv
// rtl/touch_scan_ctrl.sv - resistive touchscreen plate sequencer, ADC requester and coordinate output
module touch_scan_ctrl
  import touch_pkg::*;
#(
  parameter int ADC_W        = 12,
  parameter int AVG_LOG2     = 2,
  parameter int SETTLE_CYC   = 64,
  parameter int SCAN_GAP_CYC = 1000,
  parameter int PEN_THRESH   = 200
) (
  input  logic             FAB_CLK,
  input  logic             MSS_RESET_N,
  input  logic             SCAN_EN,
  output logic [3:0]       DRIVE,
  output logic [3:0]       DRIVE_OE,
  output logic             ADC_REQ,
  output logic             ADC_CH,
  input  logic             ADC_ACK,
  input  logic [ADC_W-1:0] ADC_DATA,
  output logic             COORD_VALID,
  input  logic             COORD_READY,
  output logic [ADC_W-1:0] COORD_X,
  output logic [ADC_W-1:0] COORD_Y,
  output logic             PEN_DOWN,
  output logic             OVERRUN
);

  localparam int CNT_MAX = (SETTLE_CYC > SCAN_GAP_CYC) ? SETTLE_CYC : SCAN_GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int NSAMP   = 1 << AVG_LOG2;
  localparam int SMP_W   = AVG_LOG2 + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [3:0]       drv_q, drv_d, oe_q, oe_d;
  logic             req_q, req_d, ch_q, ch_d;
  logic             pen_q, pen_d, valid_q, valid_d, ovr_q, ovr_d;
  logic [ADC_W-1:0] xhold_q, xhold_d, cx_q, cx_d, cy_q, cy_d;
  logic             acc_clr, acc_add, load, ack, last_smp, settle_done, gap_done;
  logic [ADC_W-1:0] avg;

  touch_avg_acc #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_acc (
    .clk        (FAB_CLK),
    .rst_n      (MSS_RESET_N),
    .clr_i      (acc_clr),
    .add_i      (acc_add),
    .sample_i   (ADC_DATA),
    .avg_next_o (avg)
  );

  // Sequencer: next state, plate pattern, request and coordinate handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    drv_d   = drv_q;
    oe_d    = oe_q;
    req_d   = req_q;
    ch_d    = ch_q;
    pen_d   = pen_q;
    xhold_d = xhold_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    load    = 1'b0;

    // ACK only counts against an outstanding request
    ack         = ADC_ACK && req_q;
    last_smp    = (smp_q == SMP_W'(NSAMP - 1));
    settle_done = (cnt_q == CNT_W'(SETTLE_CYC - 1));
    gap_done    = (cnt_q == CNT_W'(SCAN_GAP_CYC - 1));

    case (state_q)
      ST_IDLE: begin
        if (SCAN_EN) begin
          state_d = ST_PEN_SETTLE;
          drv_d   = PAT_PEN.drive;
          oe_d    = PAT_PEN.oe;
          ch_d    = CH_YP;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      end

      ST_PEN_SETTLE, ST_X_SETTLE, ST_Y_SETTLE: begin
        if (!SCAN_EN) begin
          state_d = ST_IDLE;
          drv_d   = PAT_OFF.drive;
          oe_d    = PAT_OFF.oe;
        end else if (settle_done) begin
          state_d = (state_q == ST_PEN_SETTLE) ? ST_PEN_SAMPLE :
                    (state_q == ST_X_SETTLE)   ? ST_X_SAMPLE   : ST_Y_SAMPLE;
          req_d   = 1'b1;
          smp_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PEN_SAMPLE, ST_X_SAMPLE, ST_Y_SAMPLE: begin
        if (!SCAN_EN) begin
          // A conversion already requested must be allowed to finish
          if (req_q && !ack) begin
            state_d = ST_ABORT;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            drv_d   = PAT_OFF.drive;
            oe_d    = PAT_OFF.oe;
          end
        end else if (ack) begin
          req_d = 1'b0;
          if (state_q == ST_PEN_SAMPLE) begin
            pen_d = (ADC_DATA >= ADC_W'(PEN_THRESH));
            if (ADC_DATA >= ADC_W'(PEN_THRESH)) begin
              state_d = ST_X_SETTLE;
              drv_d   = PAT_X.drive;
              oe_d    = PAT_X.oe;
              ch_d    = CH_YP;
              cnt_d   = '0;
              acc_clr = 1'b1;
            end else begin
              state_d = ST_GAP;
              drv_d   = PAT_OFF.drive;
              oe_d    = PAT_OFF.oe;
              cnt_d   = '0;
            end
          end else begin
            acc_add = 1'b1;
            if (!last_smp) begin
              smp_d = smp_q + 1'b1;
            end else if (state_q == ST_X_SAMPLE) begin
              xhold_d = avg;
              state_d = ST_Y_SETTLE;
              drv_d   = PAT_Y.drive;
              oe_d    = PAT_Y.oe;
              ch_d    = CH_XP;
              cnt_d   = '0;
              acc_clr = 1'b1;
            end else begin
              load    = 1'b1;
              state_d = ST_GAP;
              drv_d   = PAT_OFF.drive;
              oe_d    = PAT_OFF.oe;
              cnt_d   = '0;
            end
          end
        end else if (!req_q) begin
          // One low cycle after each ACK, then request the next sample
          req_d = 1'b1;
        end
      end

      ST_ABORT: begin
        if (ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          drv_d   = PAT_OFF.drive;
          oe_d    = PAT_OFF.oe;
        end
      end

      ST_GAP: begin
        if (gap_done) begin
          if (SCAN_EN) begin
            state_d = ST_PEN_SETTLE;
            drv_d   = PAT_PEN.drive;
            oe_d    = PAT_PEN.oe;
            ch_d    = CH_YP;
            cnt_d   = '0;
            acc_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        drv_d   = PAT_OFF.drive;
        oe_d    = PAT_OFF.oe;
      end
    endcase

    // A completed pair always loads; it is an overrun only if the old pair is
    // still unread and not being accepted in this same cycle.
    if (load) begin
      cx_d    = xhold_q;
      cy_d    = avg;
      valid_d = 1'b1;
      if (valid_q && !COORD_READY) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && COORD_READY) begin
      valid_d = 1'b0;
    end

    if (!SCAN_EN) begin
      ovr_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      smp_q   <= '0;
      drv_q   <= '0;
      oe_q    <= '0;
      req_q   <= 1'b0;
      ch_q    <= 1'b0;
      pen_q   <= 1'b0;
      xhold_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      drv_q   <= drv_d;
      oe_q    <= oe_d;
      req_q   <= req_d;
      ch_q    <= ch_d;
      pen_q   <= pen_d;
      xhold_q <= xhold_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign DRIVE       = drv_q;
  assign DRIVE_OE    = oe_q;
  assign ADC_REQ     = req_q;
  assign ADC_CH      = ch_q;
  assign COORD_VALID = valid_q;
  assign COORD_X     = cx_q;
  assign COORD_Y     = cy_q;
  assign PEN_DOWN    = pen_q;
  assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// tb/tb_touch_scan_ctrl.sv - directed self-checking bench for touch_scan_ctrl
module tb_touch_scan_ctrl;

  localparam int S = 4;
  localparam int G = 10;

  logic        FAB_CLK = 1'b0;
  logic        MSS_RESET_N = 1'b0;
  logic        SCAN_EN = 1'b0;
  logic [3:0]  DRIVE, DRIVE_OE;
  logic        ADC_REQ, ADC_CH;
  logic        ADC_ACK = 1'b0;
  logic [11:0] ADC_DATA = '0;
  logic        COORD_VALID;
  logic        COORD_READY = 1'b0;
  logic [11:0] COORD_X, COORD_Y;
  logic        PEN_DOWN, OVERRUN;

  int total = 0;
  int bad = 0;

  touch_scan_ctrl #(
    .ADC_W(12), .AVG_LOG2(2), .SETTLE_CYC(S), .SCAN_GAP_CYC(G), .PEN_THRESH(200)
  ) dut (
    .FAB_CLK(FAB_CLK), .MSS_RESET_N(MSS_RESET_N), .SCAN_EN(SCAN_EN),
    .DRIVE(DRIVE), .DRIVE_OE(DRIVE_OE), .ADC_REQ(ADC_REQ), .ADC_CH(ADC_CH),
    .ADC_ACK(ADC_ACK), .ADC_DATA(ADC_DATA), .COORD_VALID(COORD_VALID),
    .COORD_READY(COORD_READY), .COORD_X(COORD_X), .COORD_Y(COORD_Y),
    .PEN_DOWN(PEN_DOWN), .OVERRUN(OVERRUN)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for REQ, optionally delay, then pulse one ACK with data
  task automatic serve(input logic [11:0] d, input int dly, output int waited);
    waited = 0;
    while (ADC_REQ !== 1'b1 && waited < 200) begin
      @(negedge FAB_CLK);
      waited++;
    end
    if (ADC_REQ !== 1'b1) begin
      total++; bad++;
      $display("FAIL req_timeout got=%b exp=1", ADC_REQ);
      waited = -1;
      return;
    end
    repeat (dly) @(negedge FAB_CLK);
    ADC_ACK = 1'b1; ADC_DATA = d;
    @(negedge FAB_CLK);
    ADC_ACK = 1'b0;
  endtask

  task automatic spurious_ack();
    ADC_ACK = 1'b1; ADC_DATA = 12'hFFF;
    @(negedge FAB_CLK);
    ADC_ACK = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge FAB_CLK);
    total++; if ({DRIVE, DRIVE_OE, ADC_REQ, ADC_CH} !== 10'd0) begin bad++; $display("FAIL rst_drive got=%h/%h/%b/%b exp=0", DRIVE, DRIVE_OE, ADC_REQ, ADC_CH); end
    total++; if ({COORD_VALID, COORD_X, COORD_Y, PEN_DOWN, OVERRUN} !== 27'd0) begin bad++; $display("FAIL rst_coord got=%b/%0d/%0d/%b/%b exp=0", COORD_VALID, COORD_X, COORD_Y, PEN_DOWN, OVERRUN); end
    MSS_RESET_N = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    total++; if (ADC_REQ !== 1'b0 || DRIVE_OE !== 4'd0) begin bad++; $display("FAIL idle_quiet got=%b/%h exp=0/0", ADC_REQ, DRIVE_OE); end
  endtask

  task automatic test_pen_up();
    int w;
    SCAN_EN = 1'b1;
    @(negedge FAB_CLK);
    total++; if (DRIVE !== 4'b0001 || DRIVE_OE !== 4'b1001 || ADC_CH !== 1'b1) begin bad++; $display("FAIL pen_pattern got=%b/%b/%b exp=0001/1001/1", DRIVE, DRIVE_OE, ADC_CH); end
    serve(12'd100, 0, w);
    total++; if (w !== S) begin bad++; $display("FAIL pen_settle_wait got=%0d exp=%0d", w, S); end
    total++; if (PEN_DOWN !== 1'b0 || DRIVE_OE !== 4'd0 || ADC_REQ !== 1'b0) begin bad++; $display("FAIL pen_up_gap got=%b/%h/%b exp=0/0/0", PEN_DOWN, DRIVE_OE, ADC_REQ); end
    serve(12'd100, 0, w);
    total++; if (w !== G + S) begin bad++; $display("FAIL gap_wait got=%0d exp=%0d", w, G + S); end
    total++; if (COORD_VALID !== 1'b0 || PEN_DOWN !== 1'b0) begin bad++; $display("FAIL pen_up_novalid got=%b/%b exp=0/0", COORD_VALID, PEN_DOWN); end
    SCAN_EN = 1'b0;
    repeat (G + 5) @(negedge FAB_CLK);
    total++; if (ADC_REQ !== 1'b0 || DRIVE_OE !== 4'd0) begin bad++; $display("FAIL stop_idle got=%b/%h exp=0/0", ADC_REQ, DRIVE_OE); end
  endtask

  task automatic test_pen_down();
    int w;
    logic [11:0] xs [4] = '{12'd100, 12'd101, 12'd102, 12'd104};
    SCAN_EN = 1'b1;
    @(negedge FAB_CLK);
    serve(12'd500, 0, w);
    total++; if (w !== S) begin bad++; $display("FAIL pd_pen_wait got=%0d exp=%0d", w, S); end
    total++; if (PEN_DOWN !== 1'b1) begin bad++; $display("FAIL pd_pen got=%b exp=1", PEN_DOWN); end
    total++; if (DRIVE !== 4'b0001 || DRIVE_OE !== 4'b0011 || ADC_CH !== 1'b1 || ADC_REQ !== 1'b0) begin bad++; $display("FAIL x_pattern got=%b/%b/%b/%b exp=0001/0011/1/0", DRIVE, DRIVE_OE, ADC_CH, ADC_REQ); end
    for (int i = 0; i < 4; i++) begin
      serve(xs[i], 0, w);
      total++; if (w !== ((i == 0) ? S : 1)) begin bad++; $display("FAIL x_req_wait%0d got=%0d exp=%0d", i, w, (i == 0) ? S : 1); end
    end
    total++; if (DRIVE !== 4'b0100 || DRIVE_OE !== 4'b1100 || ADC_CH !== 1'b0) begin bad++; $display("FAIL y_pattern got=%b/%b/%b exp=0100/1100/0", DRIVE, DRIVE_OE, ADC_CH); end
    for (int i = 0; i < 4; i++) begin
      serve(12'd3000, 0, w);
      if (i == 2) begin
        total++; if (COORD_VALID !== 1'b0) begin bad++; $display("FAIL pd_early_valid got=%b exp=0", COORD_VALID); end
      end
    end
    total++; if (COORD_VALID !== 1'b1) begin bad++; $display("FAIL pd_valid got=%b exp=1", COORD_VALID); end
    total++; if (COORD_X !== 12'd101 || COORD_Y !== 12'd3000) begin bad++; $display("FAIL pd_coord got=%0d/%0d exp=101/3000", COORD_X, COORD_Y); end
    total++; if (DRIVE_OE !== 4'd0 || OVERRUN !== 1'b0) begin bad++; $display("FAIL pd_gap got=%h/%b exp=0/0", DRIVE_OE, OVERRUN); end
  endtask

  task automatic test_overrun();
    int w;
    logic [11:0] xs [4] = '{12'd40, 12'd40, 12'd40, 12'd43};
    logic [11:0] ys [4] = '{12'd7, 12'd8, 12'd9, 12'd10};
    serve(12'd500, 0, w);
    total++; if (w !== G + S) begin bad++; $display("FAIL ov_gap_wait got=%0d exp=%0d", w, G + S); end
    for (int i = 0; i < 4; i++) serve(xs[i], 0, w);
    for (int i = 0; i < 3; i++) serve(ys[i], 0, w);
    total++; if (COORD_VALID !== 1'b1 || COORD_X !== 12'd101 || COORD_Y !== 12'd3000) begin bad++; $display("FAIL ov_hold got=%b/%0d/%0d exp=1/101/3000", COORD_VALID, COORD_X, COORD_Y); end
    serve(ys[3], 0, w);
    total++; if (COORD_VALID !== 1'b1 || COORD_X !== 12'd40 || COORD_Y !== 12'd8) begin bad++; $display("FAIL ov_coord got=%b/%0d/%0d exp=1/40/8", COORD_VALID, COORD_X, COORD_Y); end
    total++; if (OVERRUN !== 1'b1) begin bad++; $display("FAIL ov_flag got=%b exp=1", OVERRUN); end
    COORD_READY = 1'b1;
    @(negedge FAB_CLK);
    COORD_READY = 1'b0;
    total++; if (COORD_VALID !== 1'b0 || OVERRUN !== 1'b1) begin bad++; $display("FAIL ready_clear got=%b/%b exp=0/1", COORD_VALID, OVERRUN); end
  endtask

  task automatic test_abort();
    int w;
    serve(12'd500, 0, w);
    w = 0;
    while (ADC_REQ !== 1'b1 && w < 200) begin @(negedge FAB_CLK); w++; end
    total++; if (ADC_REQ !== 1'b1 || DRIVE_OE !== 4'b0011) begin bad++; $display("FAIL ab_xreq got=%b/%b exp=1/0011", ADC_REQ, DRIVE_OE); end
    SCAN_EN = 1'b0;
    repeat (5) @(negedge FAB_CLK);
    total++; if (ADC_REQ !== 1'b1) begin bad++; $display("FAIL ab_req_held got=%b exp=1", ADC_REQ); end
    ADC_ACK = 1'b1; ADC_DATA = 12'd900;
    @(negedge FAB_CLK);
    ADC_ACK = 1'b0;
    total++; if (ADC_REQ !== 1'b0 || DRIVE_OE !== 4'd0) begin bad++; $display("FAIL ab_idle got=%b/%h exp=0/0", ADC_REQ, DRIVE_OE); end
    repeat (30) @(negedge FAB_CLK);
    total++; if (ADC_REQ !== 1'b0 || COORD_VALID !== 1'b0 || OVERRUN !== 1'b0) begin bad++; $display("FAIL ab_after got=%b/%b/%b exp=0/0/0", ADC_REQ, COORD_VALID, OVERRUN); end
    total++; if (COORD_X !== 12'd40 || COORD_Y !== 12'd8) begin bad++; $display("FAIL ab_coord got=%0d/%0d exp=40/8", COORD_X, COORD_Y); end
  endtask

  task automatic test_ack_delay();
    int w;
    SCAN_EN = 1'b1;
    serve(12'd500, 20, w);
    spurious_ack();
    for (int i = 0; i < 4; i++) begin
      serve(12'(1000 + i), (i % 2 == 0) ? 0 : 20, w);
      spurious_ack();
    end
    for (int i = 0; i < 4; i++) begin
      serve(12'(2000 + i), (i % 2 == 0) ? 20 : 0, w);
      if (i < 3) spurious_ack();
    end
    total++; if (COORD_VALID !== 1'b1 || COORD_X !== 12'd1001 || COORD_Y !== 12'd2001) begin bad++; $display("FAIL dly_coord got=%b/%0d/%0d exp=1/1001/2001", COORD_VALID, COORD_X, COORD_Y); end
    total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL dly_ovr got=%b exp=0", OVERRUN); end
  endtask

  task automatic test_reset_mid_scan();
    int w;
    serve(12'd500, 0, w);
    w = 0;
    while (ADC_REQ !== 1'b1 && w < 200) begin @(negedge FAB_CLK); w++; end
    total++; if (ADC_REQ !== 1'b1 || ADC_CH !== 1'b1) begin bad++; $display("FAIL rm_inx got=%b/%b exp=1/1", ADC_REQ, ADC_CH); end
    MSS_RESET_N = 1'b0;
    SCAN_EN = 1'b0;
    #1;
    total++; if ({DRIVE, DRIVE_OE, ADC_REQ, ADC_CH} !== 10'd0) begin bad++; $display("FAIL rm_drive got=%h/%h/%b/%b exp=0", DRIVE, DRIVE_OE, ADC_REQ, ADC_CH); end
    total++; if ({COORD_VALID, COORD_X, COORD_Y, PEN_DOWN, OVERRUN} !== 27'd0) begin bad++; $display("FAIL rm_coord got=%b/%0d/%0d/%b/%b exp=0", COORD_VALID, COORD_X, COORD_Y, PEN_DOWN, OVERRUN); end
    @(negedge FAB_CLK);
    MSS_RESET_N = 1'b1;
    repeat (20) @(negedge FAB_CLK);
    total++; if (ADC_REQ !== 1'b0) begin bad++; $display("FAIL rm_noreq got=%b exp=0", ADC_REQ); end
    SCAN_EN = 1'b1;
    serve(12'd100, 0, w);
    total++; if (w !== S + 1) begin bad++; $display("FAIL rm_restart_wait got=%0d exp=%0d", w, S + 1); end
    SCAN_EN = 1'b0;
    repeat (G + 5) @(negedge FAB_CLK);
  endtask

  initial begin
    test_reset();
    test_pen_up();
    test_pen_down();
    test_overrun();
    test_abort();
    test_ack_delay();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
